// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, plane byte lanes and state encoding for the plane fetcher
package vga_pkg;
  localparam int C_frame_words = 38400;
  localparam int C_red_lsb = 0;
  localparam int C_green_lsb = 8;
  localparam int C_blue_lsb = 16;
  localparam int C_bright_lsb = 24;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REQ} state_t;
endpackage

// File: rtl/vga_fifo_ram.sv
// vga_fifo_ram: simple dual-port word store, synchronous write, asynchronous read
module vga_fifo_ram #(
  parameter int C_log2 = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [C_log2-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [C_log2-1:0] i_raddr,
  output logic [31:0]       o_rdata
);
  logic [31:0] r_mem [2**C_log2];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/vga_plane_fetch.sv
// vga_plane_fetch: bus-mastering show-ahead prefetch of bitplane words for VGA scanout
module vga_plane_fetch #(
  parameter int C_addr_bits = 30,
  parameter int C_fifo_log2 = 4,
  parameter int C_frame_words = vga_pkg::C_frame_words
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [C_addr_bits-1:0] base_addr,
  input  logic                   vga_vsync,
  input  logic                   rd,
  output logic                   addr_strobe,
  output logic [C_addr_bits-1:0] addr,
  input  logic                   data_ready,
  input  logic [31:0]            data_in,
  output logic [7:0]             red_byte,
  output logic [7:0]             green_byte,
  output logic [7:0]             blue_byte,
  output logic [7:0]             bright_byte,
  output logic                   underflow
);
  import vga_pkg::*;
  localparam int C_lw = C_fifo_log2 + 1;
  logic r_vs1, r_vs2, r_vs3, r_discard, r_underflow;
  state_t r_state, w_next;
  logic [C_fifo_log2-1:0] r_rptr, r_wptr;
  logic [C_lw-1:0] r_level;
  logic [15:0] r_fetched;
  logic [C_addr_bits-1:0] r_base, r_addr;
  logic [31:0] w_head;
  logic w_restart, w_empty, w_done, w_ack, w_push, w_pop;
  assign w_restart = r_vs3 & ~r_vs2;
  assign w_empty = r_level == '0;
  assign w_done = r_fetched == 16'(C_frame_words);
  assign w_ack = (r_state == S_REQ) & data_ready;
  // a word answering a request issued before the restart belongs to the old frame
  assign w_push = w_ack & ~r_discard & ~w_restart;
  assign w_pop = rd & ~w_empty & ~w_restart;
  always_ff @(posedge clk or posedge reset)
    if (reset) {r_vs1, r_vs2, r_vs3} <= 3'b111;
    else {r_vs1, r_vs2, r_vs3} <= {vga_vsync, r_vs1, r_vs2};
  // REQ ignores restart so the bus request stays stable until answered
  always_comb begin
    w_next = r_state;
    if (r_state == S_REQ) w_next = data_ready ? S_FILL : S_REQ;
    else if (w_restart) w_next = S_FILL;
    else if (r_state == S_FILL) w_next = w_done ? S_IDLE : r_level[C_fifo_log2] ? S_FILL : S_REQ;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_discard <= 1'b0;
      r_underflow <= 1'b0;
      r_rptr <= '0;
      r_wptr <= '0;
      r_level <= '0;
      r_fetched <= '0;
      r_base <= '0;
      r_addr <= '0;
    end else begin
      r_state <= w_next;
      r_discard <= w_ack ? 1'b0 : r_discard | (w_restart & (r_state == S_REQ));
      r_underflow <= r_underflow | (rd & w_empty);
      if (r_state == S_FILL && w_next == S_REQ) r_addr <= r_base + C_addr_bits'(r_fetched);
      if (w_restart) begin
        r_rptr <= '0;
        r_wptr <= '0;
        r_level <= '0;
        r_fetched <= '0;
        r_base <= base_addr;
      end else begin
        r_wptr <= r_wptr + C_fifo_log2'(w_push);
        r_rptr <= r_rptr + C_fifo_log2'(w_pop);
        r_level <= r_level + C_lw'(w_push) - C_lw'(w_pop);
        r_fetched <= r_fetched + 16'(w_push);
      end
    end
  end
  vga_fifo_ram #(.C_log2(C_fifo_log2)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );
  assign addr_strobe = r_state == S_REQ;
  assign addr = r_addr;
  assign underflow = r_underflow;
  assign red_byte = w_empty ? 8'h00 : w_head[C_red_lsb +: 8];
  assign green_byte = w_empty ? 8'h00 : w_head[C_green_lsb +: 8];
  assign blue_byte = w_empty ? 8'h00 : w_head[C_blue_lsb +: 8];
  assign bright_byte = w_empty ? 8'h00 : w_head[C_bright_lsb +: 8];
endmodule

// File: tb/tb_vga_plane_fetch.sv
// tb_vga_plane_fetch: directed scenarios against a small-frame plane fetcher with a latency-programmable memory
module tb_vga_plane_fetch;
  logic clk = 1'b0;
  logic reset, vga_vsync, rd;
  logic [29:0] base_addr, addr;
  logic addr_strobe, underflow;
  logic data_ready = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0] red_byte, green_byte, blue_byte, bright_byte;
  logic [31:0] bytes_w;
  int tot = 0;
  int bad = 0;
  int mem_lat = 2;
  int mem_mode = 0;
  int mem_cnt = 0;
  int log_n = 0;
  int stb_cycles = 0;
  logic [29:0] log_a [0:511];

  vga_plane_fetch #(.C_addr_bits(30), .C_fifo_log2(4), .C_frame_words(20)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .vga_vsync(vga_vsync), .rd(rd),
    .addr_strobe(addr_strobe), .addr(addr), .data_ready(data_ready), .data_in(data_in),
    .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
    .bright_byte(bright_byte), .underflow(underflow)
  );

  always #5 clk = ~clk;
  assign bytes_w = {bright_byte, blue_byte, green_byte, red_byte};

  function automatic logic [31:0] word_of(input logic [29:0] a, input int mode);
    logic [7:0] lo;
    lo = a[7:0];
    return (mode != 0) ? 32'hAABBCCDD : {~lo, 4'h5, a[11:8], lo + 8'h20, lo + 8'h10};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      data_ready = 1'b0;
      mem_cnt = 0;
    end else if (data_ready) begin
      data_ready = 1'b0;
      mem_cnt = 0;
    end else if (addr_strobe) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        data_ready = 1'b1;
        data_in = word_of(addr, mem_mode);
      end
    end
  end

  always @(posedge clk) begin
    if (addr_strobe && data_ready) begin
      log_a[log_n] <= addr;
      log_n <= log_n + 1;
    end
    if (addr_strobe) stb_cycles <= stb_cycles + 1;
  end

  task automatic wait_log(input int target, input int limit, output bit ok);
    int k;
    k = 0;
    while (log_n < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    ok = (log_n >= target);
  endtask

  task automatic vsync_fall;
    vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    vga_vsync = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tot++; if (addr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", addr_strobe); end
    tot++; if (addr !== 30'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr); end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL reset_bytes got=%h exp=00000000", bytes_w); end
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    tot++; if (stb_cycles !== 0) begin bad++; $display("FAIL idle_strobe_cycles got=%0d exp=0", stb_cycles); end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL idle_bytes got=%h exp=00000000", bytes_w); end
  endtask

  task automatic test_fill;
    int n0;
    bit ok;
    base_addr = 30'h100;
    mem_mode = 0;
    mem_lat = 2;
    n0 = log_n;
    vsync_fall();
    wait_log(n0 + 16, 300, ok);
    tot++; if (!ok) begin bad++; $display("FAIL fill_timeout got=%0d exp=%0d", log_n - n0, 16); end
    repeat (20) @(negedge clk);
    tot++; if (log_n - n0 !== 16) begin bad++; $display("FAIL fill_count got=%0d exp=16", log_n - n0); end
    tot++; if (addr_strobe !== 1'b0) begin bad++; $display("FAIL fill_full_strobe got=%b exp=0", addr_strobe); end
    for (int i = 0; i < 16; i++) begin
      tot++; if (log_a[n0 + i] !== 30'h100 + 30'(i)) begin bad++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, log_a[n0 + i], 30'h100 + 30'(i)); end
    end
    tot++; if (bytes_w !== 32'hFF512010) begin bad++; $display("FAIL fill_head got=%h exp=FF512010", bytes_w); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    tot++; if (bytes_w !== 32'hFE512111) begin bad++; $display("FAIL pop_head got=%h exp=FE512111", bytes_w); end
    wait_log(n0 + 17, 50, ok);
    tot++; if (!ok) begin bad++; $display("FAIL refill_timeout got=%0d exp=17", log_n - n0); end
    tot++; if (log_a[n0 + 16] !== 30'h110) begin bad++; $display("FAIL refill_addr got=%h exp=110", log_a[n0 + 16]); end
  endtask

  task automatic test_drain;
    int n0;
    bit ok;
    mem_mode = 1;
    base_addr = 30'h100;
    n0 = log_n;
    vsync_fall();
    wait_log(n0 + 16, 300, ok);
    tot++; if (!ok) begin bad++; $display("FAIL drain_fill_timeout got=%0d exp=16", log_n - n0); end
    tot++; if (red_byte !== 8'hDD) begin bad++; $display("FAIL drain_red got=%h exp=DD", red_byte); end
    tot++; if (green_byte !== 8'hCC) begin bad++; $display("FAIL drain_green got=%h exp=CC", green_byte); end
    tot++; if (blue_byte !== 8'hBB) begin bad++; $display("FAIL drain_blue got=%h exp=BB", blue_byte); end
    tot++; if (bright_byte !== 8'hAA) begin bad++; $display("FAIL drain_bright got=%h exp=AA", bright_byte); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    wait_log(n0 + 17, 50, ok);
    tot++; if (!ok) begin bad++; $display("FAIL drain_next_timeout got=%0d exp=17", log_n - n0); end
    tot++; if (log_a[n0 + 16] !== 30'h110) begin bad++; $display("FAIL drain_next_addr got=%h exp=110", log_a[n0 + 16]); end
    tot++; if (bytes_w !== 32'hAABBCCDD) begin bad++; $display("FAIL drain_after_pop got=%h exp=AABBCCDD", bytes_w); end
  endtask

  task automatic test_frame_end;
    int n0;
    mem_mode = 0;
    mem_lat = 1;
    base_addr = 30'h200;
    n0 = log_n;
    vsync_fall();
    repeat (150) begin
      @(negedge clk);
      rd = (red_byte != 8'h00);
    end
    rd = 1'b0;
    @(negedge clk);
    tot++; if (log_n - n0 !== 20) begin bad++; $display("FAIL frame_count got=%0d exp=20", log_n - n0); end
    tot++; if (log_a[n0] !== 30'h200) begin bad++; $display("FAIL frame_first got=%h exp=200", log_a[n0]); end
    tot++; if (log_a[n0 + 19] !== 30'h213) begin bad++; $display("FAIL frame_last got=%h exp=213", log_a[n0 + 19]); end
    tot++; if (addr_strobe !== 1'b0) begin bad++; $display("FAIL frame_idle_strobe got=%b exp=0", addr_strobe); end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL frame_empty_bytes got=%h exp=00000000", bytes_w); end
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL frame_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_restart_mid;
    int n0, n1, k;
    bit ok;
    mem_mode = 0;
    mem_lat = 2;
    base_addr = 30'h300;
    n0 = log_n;
    vsync_fall();
    wait_log(n0 + 3, 100, ok);
    tot++; if (!ok) begin bad++; $display("FAIL mid_prefill_timeout got=%0d exp=3", log_n - n0); end
    mem_lat = 16;
    k = 0;
    while (!addr_strobe && k < 20) begin
      @(negedge clk);
      k++;
    end
    tot++; if (addr_strobe !== 1'b1) begin bad++; $display("FAIL mid_req_timeout got=%b exp=1", addr_strobe); end
    tot++; if (addr !== 30'h303) begin bad++; $display("FAIL mid_req_addr got=%h exp=303", addr); end
    tot++; if (bytes_w !== 32'hFF532010) begin bad++; $display("FAIL mid_head_before got=%h exp=FF532010", bytes_w); end
    base_addr = 30'h400;
    n1 = log_n;
    vsync_fall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tot++; if ({addr_strobe, addr} !== {1'b1, 30'h303}) begin bad++; $display("FAIL mid_hold[%0d] got=%b/%h exp=1/303", i, addr_strobe, addr); end
    end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL mid_flushed got=%h exp=00000000", bytes_w); end
    wait_log(n1 + 1, 40, ok);
    tot++; if (!ok) begin bad++; $display("FAIL mid_discard_timeout got=%0d exp=1", log_n - n1); end
    tot++; if (log_a[n1] !== 30'h303) begin bad++; $display("FAIL mid_discard_addr got=%h exp=303", log_a[n1]); end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL mid_discarded got=%h exp=00000000", bytes_w); end
    wait_log(n1 + 2, 100, ok);
    tot++; if (!ok) begin bad++; $display("FAIL mid_new_timeout got=%0d exp=2", log_n - n1); end
    tot++; if (log_a[n1 + 1] !== 30'h400) begin bad++; $display("FAIL mid_new_addr got=%h exp=400", log_a[n1 + 1]); end
    tot++; if (bytes_w !== 32'hFF542010) begin bad++; $display("FAIL mid_new_head got=%h exp=FF542010", bytes_w); end
  endtask

  task automatic test_underflow;
    int n0;
    bit ok;
    mem_lat = 1;
    repeat (100) @(negedge clk);
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_before got=%b exp=0", underflow); end
    base_addr = 30'h500;
    n0 = log_n;
    vsync_fall();
    @(negedge clk);
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL uf_empty got=%h exp=00000000", bytes_w); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    tot++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", underflow); end
    wait_log(n0 + 16, 300, ok);
    tot++; if (!ok) begin bad++; $display("FAIL uf_refill_timeout got=%0d exp=16", log_n - n0); end
    tot++; if (bytes_w !== 32'hFF552010) begin bad++; $display("FAIL uf_refill_head got=%h exp=FF552010", bytes_w); end
    tot++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_after_refill got=%b exp=1", underflow); end
    base_addr = 30'h600;
    vsync_fall();
    @(negedge clk);
    tot++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_after_restart got=%b exp=1", underflow); end
    reset = 1'b1;
    @(negedge clk);
    tot++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_reset got=%b exp=0", underflow); end
    tot++; if ({addr_strobe, addr} !== 31'h0) begin bad++; $display("FAIL uf_reset_bus got=%b/%h exp=0/0", addr_strobe, addr); end
    tot++; if (bytes_w !== 32'h0) begin bad++; $display("FAIL uf_reset_bytes got=%h exp=00000000", bytes_w); end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    vga_vsync = 1'b1;
    rd = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_frame_end();
    test_restart_mid();
    test_underflow();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule

// File: doc/vga_plane_fetch.md
# vga_plane_fetch

Bus-mastering prefetch buffer that sits directly upstream of the 640x480 VGA/HDMI bitplane scanout stage. It reads one 32-bit word per 8-pixel group from main memory and buffers words in a show-ahead FIFO. It presents the head word as the four plane bytes (red, green, blue, bright) and pops on the scanout stage's one-cycle `rd` pulse. The active-low VGA vsync restarts the frame: the FIFO is flushed and fetching resumes from the base address.

## Interface
Parameters:
- `C_addr_bits`, 30, word-address width of the memory bus.
- `C_fifo_log2`, 4, FIFO depth is 2**C_fifo_log2 words.
- `C_frame_words`, 38400, words fetched per frame (80 groups x 480 lines).

Ports:
- `clk`  in  1  CPU/bus clock; single clock domain (already decided).
- `reset`  in  1  asynchronous, active-high reset (already decided).
- `base_addr`  in  C_addr_bits  frame word address; sampled at each frame restart.
- `vga_vsync`  in  1  active-low vsync from the pixel-clock domain; asynchronous to `clk`.
- `rd`  in  1  one-`clk` pulse: the head word has been consumed.
- `addr_strobe`  out  1  memory read request.
- `addr`  out  C_addr_bits  word address of the request.
- `data_ready`  in  1  memory read complete; `data_in` is valid this cycle.
- `data_in`  in  32  read data: [7:0] red, [15:8] green, [23:16] blue, [31:24] bright.
- `red_byte`, `green_byte`, `blue_byte`, `bright_byte`  out  8 each  plane bytes of the FIFO head.
- `underflow`  out  1  sticky flag: `rd` arrived while the FIFO was empty.

## Operation
- **vsync synchronizer:** two flops, then an edge register. A synchronized 1->0 transition of `vga_vsync` raises `restart` for one cycle.
- **restart effects:**
  - level, read pointer and write pointer cleared.
  - `fetched` count cleared.
  - `base_addr` latched into `base_q`.
  - state goes to FILL.
- **States:**
  - IDLE: no requests. Entered from reset and after `fetched` reaches C_frame_words.
  - FILL: when `level < 2**C_fifo_log2` and `fetched < C_frame_words`, go to REQ.
  - REQ: `addr_strobe`=1, `addr`=`base_q + fetched`. Hold both until `data_ready`. On `data_ready`: push `data_in`, `fetched`+1, return to FILL.
  - FILL->IDLE when `fetched == C_frame_words`.
- **Bus rule:** once raised, `addr_strobe` and `addr` stay stable until `data_ready`, even across `restart`.
- **restart during REQ:**
  - Set `discard`.
  - Stay in REQ with the old address.
  - On `data_ready`, drop the word (no push, no count).
  - Then proceed from FILL with the restarted frame.
- **Pop:** `rd`=1 and `level > 0` advances the read pointer.
- **Pop on empty:** `rd`=1 and `level == 0` sets `underflow`. Only `reset` clears it.
- **Simultaneous push and pop:** level unchanged, both pointers advance.
- **restart coincident with pop or push:** restart wins; the FIFO ends empty.
- **Output bytes:** FIFO head word when `level > 0`, all-zero when empty (renders black).
- **Arithmetic:**
  - Pointers wrap modulo 2**C_fifo_log2.
  - `level` is C_fifo_log2+1 bits.
  - `fetched` is 16 bits.
  - Address sum is truncated to C_addr_bits.

## Timing
- **Reset values:** `addr_strobe`=0, `addr`=0, all bytes 0, `underflow`=0, level 0, state IDLE, `discard`=0.
- **vsync to restart:** `restart` is effective 3 `clk` edges after `vga_vsync` falls (2 sync + 1 edge).
- **Request issue:** `addr_strobe` rises the cycle after FILL sees space.
- **Request spacing:** minimum 2 `clk` between consecutive requests (FILL, REQ).
- **Push latency:** `data_ready` at edge N pushes the word; it is visible on the byte outputs after edge N if the FIFO was empty.
- **Pop latency:** `rd` sampled at edge N; the next word is on the outputs after edge N.
- **Throughput requirement:** the consumer issues at most one `rd` per 8 pixel clocks. The bus must sustain this, with the FIFO absorbing latency.

## Structure
- Shared package `vga_pkg` holds:
  - `C_frame_words`;
  - the plane byte-lane offsets;
  - the state encoding (IDLE, FILL, REQ).
- One sub-module: `vga_fifo_ram`, a simple dual-port RAM (2**C_fifo_log2 x 32), synchronous write and asynchronous read, so the show-ahead head is combinational from the read pointer.
- Pointers, level, FSM and synchronizer stay in the top module.

## Test plan
- **Reset then idle:** reset, hold `vga_vsync` high 100 cycles -> `addr_strobe` never rises; bytes 0.
- **Fill to full:** `vga_vsync` low, `base_addr`=0x100, memory answers in 2 cycles, no `rd` -> 16 requests at 0x100..0x10F, then strobe stays low; head bytes = word at 0x100.
- **Steady drain:** fill with `data_in`=0xAABBCCDD; pulse `rd` -> red 0xDD, green 0xCC, blue 0xBB, bright 0xAA; next request at 0x110 follows.
- **Frame end:** C_frame_words=20, continuous `rd` -> exactly 20 requests, last at base+19, then IDLE.
- **Restart mid-request:** vsync falls while REQ waits 10 cycles -> strobe and addr held; returned word discarded; next request at the new `base_addr`; level 0 after restart.
- **Underflow:** `rd` with empty FIFO -> `underflow`=1 and stays 1 after refill and subsequent restarts until reset.
